// File: rtl/muxn_rr_reg_if.sv
// Handshake bundle between N producers, the registered mux and one consumer.
// master = producer/consumer side, slave = mux side.
interface muxn_rr_reg_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH-1:0]    in_ready;
    logic [DW-1:0]      out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/muxn_rr_reg.sv
// N-channel registered mux, fixed-select or round-robin arbitration.
// Latency: 1 cycle from input transfer to out_valid; 1 transfer/cycle sustained.
// Backpressure: out_ready low with a held word stalls the register and drops every in_ready.
module muxn_rr_reg #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    muxn_rr_reg_if.slave         bus
);
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,   rr_ptr_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_ch;
    logic [DW-1:0]    grant_dat;
    logic             load_en;
    logic             xfer;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_dat = '0;
        if (mode) begin
            // Walk channels from rr_ptr upward, wrapping at N_CH (not at 2**SEL_W).
            for (int off = 0; off < N_CH; off++) begin
                idx = int'(rr_ptr_q) + off;
                if (idx >= N_CH) idx = idx - N_CH;
                for (int k = 0; k < N_CH; k++) begin
                    if (!grant_vld && idx == k && bus.in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_ch  = SEL_W'(k);
                    end
                end
            end
        end else begin
            // Out-of-range sel matches no k, so nothing is granted.
            for (int k = 0; k < N_CH; k++) begin
                if (sel == SEL_W'(k) && bus.in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_ch  = sel;
                end
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (grant_ch == SEL_W'(k)) grant_dat = bus.in_data[k*DW +: DW];
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = grant_vld && load_en && rst_n;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            bus.in_ready[k] = xfer && (grant_ch == SEL_W'(k));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = grant_dat;
            out_ch_d    = grant_ch;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = (grant_ch == SEL_W'(N_CH - 1)) ? '0 : grant_ch + SEL_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg (N_CH=4, DW=8): reset, fixed select, round-robin,
// skip/wrap, backpressure, drain and mid-stream reset.
module tb_muxn_rr_reg;
    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    int         tests;
    int         fails;

    muxn_rr_reg_if #(.N_CH(4), .DW(8)) bus ();

    muxn_rr_reg #(.N_CH(4), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_dat [4];
    logic [1:0] exp_rr3 [4];
    logic [3:0] onehot;

    initial begin
        tests = 0;
        fails = 0;
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_rr3 = '{2'd3, 2'd0, 2'd3, 2'd0};

        // Reset with live inputs: nothing may be accepted.
        rst_n         = 1'b0;
        mode          = 1'b0;
        sel           = 2'd0;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_ch",    32'(bus.out_ch),    32'h0);
        chk("rst_in_ready2", 32'(bus.in_ready),  32'h0);

        // Fixed select, each channel in turn.
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel    = 2'(s);
            onehot = 4'b0001 << s;
            #1;
            chk("fix_in_ready", 32'(bus.in_ready), 32'(onehot));
            tick();
            chk("fix_out_data",  32'(bus.out_data),  32'(exp_dat[s]));
            chk("fix_out_ch",    32'(bus.out_ch),    32'(s));
            chk("fix_out_valid", 32'(bus.out_valid), 32'h1);
        end

        // Round-robin, all valid: rr_ptr is still 0 from reset.
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            onehot = 4'b0001 << (i % 4);
            #1;
            chk("rr_in_ready", 32'(bus.in_ready), 32'(onehot));
            tick();
            chk("rr_out_ch",   32'(bus.out_ch),   32'(i % 4));
            chk("rr_out_data", 32'(bus.out_data), 32'(exp_dat[i % 4]));
        end

        // Mid-stream reset after grants to 0 and 1.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("pre_rst_ch", 32'(bus.out_ch), 32'(i));
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_out_data",  32'(bus.out_data),  32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk("post_rst_out_ch",    32'(bus.out_ch),    32'h0);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h1);

        // Skip and wrap: rr_ptr=1, only channels 0 and 3 valid.
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            onehot = 4'b0001 << exp_rr3[i];
            #1;
            chk("skip_in_ready", 32'(bus.in_ready), 32'(onehot));
            tick();
            chk("skip_out_ch", 32'(bus.out_ch), 32'(exp_rr3[i]));
        end

        // Backpressure: load 22 from channel 1 (rr_ptr=1), then stall.
        bus.in_valid = 4'hF;
        #1;
        chk("bp_load_rdy", 32'(bus.in_ready), 32'b0010);
        tick();
        chk("bp_load_data", 32'(bus.out_data), 32'h22);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            tick();
            chk("bp_out_data",  32'(bus.out_data),  32'h22);
            chk("bp_out_ch",    32'(bus.out_ch),    32'h1);
            chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume_rdy", 32'(bus.in_ready), 32'b0100);
        tick();
        chk("bp_resume_ch",   32'(bus.out_ch),   32'h2);
        chk("bp_resume_data", 32'(bus.out_data), 32'h33);

        // Fixed select on an idle channel, then nothing valid: output drains.
        mode         = 1'b0;
        sel          = 2'd2;
        bus.in_valid = 4'b1011;
        #1;
        chk("drain_rdy1", 32'(bus.in_ready), 32'h0);
        tick();
        chk("drain_valid1", 32'(bus.out_valid), 32'h0);
        chk("drain_hold_data", 32'(bus.out_data), 32'h33);
        sel          = 2'd3;
        bus.in_valid = 4'b0000;
        #1;
        chk("drain_rdy2", 32'(bus.in_ready), 32'h0);
        tick();
        chk("drain_valid2", 32'(bus.out_valid), 32'h0);
        chk("drain_hold_ch", 32'(bus.out_ch), 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
